// File: rtl/tc_ps_gp_rd_arb.sv
// Two-requester round-robin arbiter and sequencer for the shared register read port.
// One read is in flight at a time: accept, single-cycle rden, wait out the
// register-file latency, capture, then hold the response until the owner takes it.
//
// state | meaning
// IDLE  | no read in flight; a valid request is granted combinationally
// ISSUE | rden pulse with the latched address; latency counter loaded
// WAIT  | counting down register-file latency; capture data when count hits 1
// RESP  | owner's response valid, held until its rsp_ready handshake
module tc_ps_gp_rd_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              rden,
  input  logic [DATA_W-1:0] data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [3:0] LAT_LD = 4'(RD_LAT);

  state_e            state_q;
  logic              owner_q;
  logic              rr_last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        lat_cnt_q;
  logic              rden_q;
  logic              busy_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_data_q;
  logic [DATA_W-1:0] rsp1_data_q;
  logic              grant0;
  logic              grant1;
  logic              rsp_hs;

  // Winner select in IDLE; on a tie the requester that did not go last wins.
  // Gated by rst so no accept pulse escapes while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst && (state_q == IDLE)) begin
      if (req0_valid && req1_valid) begin
        grant0 = rr_last_q;
        grant1 = ~rr_last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign rsp_hs = owner_q ? (rsp1_valid_q & rsp1_ready) : (rsp0_valid_q & rsp0_ready);

  // Sequencer FSM with registered strobe, busy and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      rr_last_q    <= 1'b1;
      addr_q       <= '0;
      lat_cnt_q    <= '0;
      rden_q       <= 1'b0;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rden_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            owner_q <= grant1;
            addr_q  <= grant1 ? req1_addr : req0_addr;
            rden_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt_q <= LAT_LD;
          state_q   <= WAIT;
        end
        WAIT: begin
          lat_cnt_q <= lat_cnt_q - 4'd1;
          if (lat_cnt_q == 4'd1) begin
            if (owner_q) begin
              rsp1_data_q  <= data;
              rsp1_valid_q <= 1'b1;
            end else begin
              rsp0_data_q  <= data;
              rsp0_valid_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rr_last_q    <= owner_q;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign addr       = addr_q;
  assign rden       = rden_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tc_ps_gp_rd_arb.sv
// Bench for tc_ps_gp_rd_arb: two instances (RD_LAT 1 and 3) share the clock.
// Each instance has a register-file model, a scoreboard monitor and a
// directed-then-random stimulus sequence.
module tb_tc_ps_gp_rd_arb;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   done [2];

  initial forever #5 clk = ~clk;

  task automatic chk(input int lat, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL L%0d %s: got 0x%0h expected 0x%0h", lat, nm, act, exp);
    end
  endtask

  task automatic tmo(input int lat, input string nm);
    checks++;
    errors++;
    $display("FAIL L%0d %s: wait expired, got no event, expected one", lat, nm);
  endtask

  // Register-file contents as a function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {16'hA5A5, a[15:0]} ^ {a[31:16], 16'h0000};
  endfunction

  function automatic logic [31:0] rnd_addr();
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_addr = '0, req1_addr = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] addr;
    logic        rden;
    logic [31:0] data = '0;
    logic        busy;

    tc_ps_gp_rd_arb #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
      .addr(addr), .rden(rden), .data(data), .busy(busy)
    );

    int          cyc = 0;
    bit          tgt_vld = 0;
    int          tgt_cyc = 0;
    logic [31:0] tgt_val = '0;

    initial forever begin
      @(posedge clk);
      cyc++;
    end

    // Register file: correct data only in the cycle RD_LAT after rden, junk otherwise.
    initial forever begin
      logic [31:0] j;
      @(posedge clk);
      #1;
      j = $urandom();
      if (tgt_vld && (cyc == tgt_cyc)) data = tgt_val;
      else data = (tgt_vld && (j == tgt_val)) ? ~j : j;
    end

    // Scoreboard monitor: reference model of one-at-a-time round-robin reads.
    bit          out = 0;
    bit          rr = 1;
    int          own = 0;
    int          acc_c = 0;
    logic [31:0] cur_addr = '0, last_addr = '0, hold0 = '0, hold1 = '0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    initial forever begin
      int          rsp_c, win;
      bit          exp_rden, any;
      logic [31:0] e;
      @(negedge clk);
      if (!rst) begin
        out = 0; rr = 1; last_addr = '0; hold0 = '0; hold1 = '0;
        q0.delete(); q1.delete(); tgt_vld = 0;
        chk(LAT, "rst busy", busy, 0);
        chk(LAT, "rst rden", rden, 0);
        chk(LAT, "rst addr", addr, 0);
        chk(LAT, "rst ready", {req0_ready, req1_ready}, 0);
        chk(LAT, "rst rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        chk(LAT, "rst rsp_data", {rsp0_data, rsp1_data}, 0);
      end else begin
        rsp_c    = acc_c + 2 + LAT;
        exp_rden = out && (cyc == acc_c + 1);
        if (exp_rden) begin
          last_addr = cur_addr;
          tgt_vld   = 1;
          tgt_cyc   = cyc + LAT;
          tgt_val   = mem_f(cur_addr);
        end
        if (out && (cyc == rsp_c)) begin
          if (own == 0 && q0.size() > 0) hold0 = q0[0];
          if (own == 1 && q1.size() > 0) hold1 = q1[0];
        end
        chk(LAT, "busy", busy, out);
        chk(LAT, "rden", rden, exp_rden);
        chk(LAT, "addr", addr, last_addr);
        chk(LAT, "rsp0_valid", rsp0_valid, out && own == 0 && cyc >= rsp_c);
        chk(LAT, "rsp1_valid", rsp1_valid, out && own == 1 && cyc >= rsp_c);
        chk(LAT, "rsp0_data", rsp0_data, hold0);
        chk(LAT, "rsp1_data", rsp1_data, hold1);
        any = req0_valid || req1_valid;
        if (req0_valid && req1_valid) win = rr ? 0 : 1;
        else win = req0_valid ? 0 : 1;
        chk(LAT, "req0_ready", req0_ready, !out && any && win == 0);
        chk(LAT, "req1_ready", req1_ready, !out && any && win == 1);
        if (out && cyc >= rsp_c && ((own == 0 && rsp0_ready) || (own == 1 && rsp1_ready))) begin
          if (own == 0) begin
            if (q0.size() > 0) begin e = q0.pop_front(); chk(LAT, "rsp0 handshake data", rsp0_data, e); end
            else tmo(LAT, "rsp0 scoreboard empty");
          end else begin
            if (q1.size() > 0) begin e = q1.pop_front(); chk(LAT, "rsp1 handshake data", rsp1_data, e); end
            else tmo(LAT, "rsp1 scoreboard empty");
          end
          rr  = (own == 1);
          out = 0;
        end else if (!out && any) begin
          own      = win;
          acc_c    = cyc;
          out      = 1;
          cur_addr = (win == 1) ? req1_addr : req0_addr;
          if (win == 1) q1.push_back(mem_f(cur_addr));
          else q0.push_back(mem_f(cur_addr));
        end
      end
    end

    // Stimulus sequence.
    bit got;
    bit a0, a1;
    int ng;
    int gr_own [6];
    int gr_cyc [6];

    initial begin
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Single req0 read of 0x10.
      @(posedge clk); #1;
      req0_valid = 1; req0_addr = 32'h10; rsp0_ready = 1;
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = req0_ready; end
      if (!got) tmo(LAT, "single req0 accept");
      @(posedge clk); #1 req0_valid = 0;
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = !busy; end
      if (!got) tmo(LAT, "single req0 drain");

      // Both requesters held valid: grants must alternate at 3+RD_LAT spacing.
      @(posedge clk); #1;
      req0_valid = 1; req0_addr = 32'h4; req1_valid = 1; req1_addr = 32'h8;
      rsp0_ready = 1; rsp1_ready = 1;
      ng = 0;
      for (int n = 0; n < 80 && ng < 6; n++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          gr_own[ng] = req1_ready ? 1 : 0;
          gr_cyc[ng] = cyc;
          ng++;
        end
      end
      if (ng < 6) tmo(LAT, "alternating grants");
      else begin
        for (int k = 0; k < 6; k++) chk(LAT, "grant order", gr_own[k], (k % 2 == 0) ? 1 : 0);
        for (int k = 1; k < 6; k++) chk(LAT, "grant spacing", gr_cyc[k] - gr_cyc[k-1], 3 + LAT);
      end
      @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = !busy; end
      if (!got) tmo(LAT, "alternating drain");

      // req1 response held back for 5 cycles while data wanders.
      @(posedge clk); #1;
      req1_valid = 1; req1_addr = 32'h30; rsp1_ready = 0; rsp0_ready = 0;
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = req1_ready; end
      if (!got) tmo(LAT, "stall req1 accept");
      @(posedge clk); #1 req1_valid = 0;
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = rsp1_valid; end
      if (!got) tmo(LAT, "stall rsp1_valid");
      repeat (5) @(negedge clk);
      @(posedge clk); #1 rsp1_ready = 1;
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = !busy; end
      if (!got) tmo(LAT, "stall drain");

      // req0 pulsed for one cycle while req1 is being served.
      @(posedge clk); #1;
      req1_valid = 1; req1_addr = 32'h40; rsp0_ready = 1;
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = req1_ready; end
      if (!got) tmo(LAT, "pulse req1 accept");
      @(posedge clk); #1;
      req1_valid = 0; req0_valid = 1; req0_addr = 32'h50;
      @(posedge clk); #1 req0_valid = 0;
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = !busy; end
      if (!got) tmo(LAT, "pulse drain");

      // Asynchronous reset in WAIT, then a fresh tie goes to req0.
      @(posedge clk); #1;
      req1_valid = 1; req1_addr = 32'h60;
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = req1_ready; end
      if (!got) tmo(LAT, "reset-case accept");
      @(posedge clk); #1 req1_valid = 0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk(LAT, "async rst busy", busy, 0);
      chk(LAT, "async rst rden", rden, 0);
      chk(LAT, "async rst rsp_valid", {rsp0_valid, rsp1_valid}, 0);
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b1;
      req0_valid = 1; req0_addr = 32'h70; req1_valid = 1; req1_addr = 32'h74;
      rsp0_ready = 1; rsp1_ready = 1;
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        got = req0_ready || req1_ready;
        if (got) chk(LAT, "post-reset first grant req0", req0_ready, 1);
      end
      if (!got) tmo(LAT, "post-reset accept");
      @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = !busy; end
      if (!got) tmo(LAT, "post-reset drain");

      // Randomised traffic: new requests, abandoned requests, random back-pressure.
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge clk); #1;
        if (req0_valid) begin
          if (a0) begin
            req0_valid = 1'($urandom_range(0, 1));
            req0_addr  = rnd_addr();
          end else if ($urandom_range(0, 7) == 0) req0_valid = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          req0_valid = 1; req0_addr = rnd_addr();
        end
        if (req1_valid) begin
          if (a1) begin
            req1_valid = 1'($urandom_range(0, 1));
            req1_addr  = rnd_addr();
          end else if ($urandom_range(0, 7) == 0) req1_valid = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          req1_valid = 1; req1_addr = rnd_addr();
        end
        rsp0_ready = ($urandom_range(0, 3) != 0);
        rsp1_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = !busy; end
      if (!got) tmo(LAT, "random drain");
      chk(LAT, "scoreboard empty", q0.size() + q1.size(), 0);
      repeat (2) @(posedge clk);
      done[g] = 1;
    end
  end

  initial begin
    for (int n = 0; n < 20000 && !(done[0] && done[1]); n++) @(posedge clk);
    if (!(done[0] && done[1])) tmo(0, "sequence completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
